// File: rtl/router_output_arbiter_if.sv
// Handshake/data bundle between the five input channels, the output arbiter and the downstream link.
// The master modport is the environment side; the slave modport is the arbiter side.
interface router_output_arbiter_if;
  logic         polarity;
  logic [4:0]   req;
  logic [319:0] data_in;
  logic         ready_out;
  logic [4:0]   blocked_in;
  logic [4:0]   gnt;
  logic         send_out;
  logic [63:0]  data_out;

  modport master (
    output polarity, req, data_in, ready_out,
    input  blocked_in, gnt, send_out, data_out
  );

  modport slave (
    input  polarity, req, data_in, ready_out,
    output blocked_in, gnt, send_out, data_out
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Five-port round-robin output arbiter with one rotating pointer per virtual channel and a registered flit stage.
// Optional saturating grant counter when ROUTER_ARB_PERF_CNT_EN is defined.
module router_output_arbiter (
  input  logic                   clk,
  input  logic                   reset,
  router_output_arbiter_if.slave bus
`ifdef ROUTER_ARB_PERF_CNT_EN
  ,
  output logic [15:0]            grant_count
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  rr_ptr_r [2];
  logic [4:0]  gnt_r;
  logic [63:0] data_r;

  logic        stall_s;
  logic        accept_s;
  logic        grant_s;
  logic [2:0]  cur_ptr_s;
  logic [2:0]  winner_s;
  logic [2:0]  ptr_next_s;
  logic        found_s;
  logic [3:0]  idx_s;

  // Handshake qualifiers and the active VC pointer (an out-of-range pointer falls back to 0)
  always_comb begin
    stall_s  = (state_r == ST_FULL) && !bus.ready_out;
    accept_s = !stall_s;
    grant_s  = accept_s && (bus.req != 5'd0);
    if (rr_ptr_r[bus.polarity] > 3'd4) begin
      cur_ptr_s = 3'd0;
    end else begin
      cur_ptr_s = rr_ptr_r[bus.polarity];
    end
  end

  // Round-robin scan: first requester at or above the pointer, wrapping 4 -> 0
  always_comb begin
    winner_s = 3'd0;
    found_s  = 1'b0;
    idx_s    = 4'd0;
    for (int k = 0; k < 5; k++) begin
      idx_s = {1'b0, cur_ptr_s} + 4'(k);
      if (idx_s > 4'd4) begin
        idx_s = idx_s - 4'd5;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.req[idx_s[2:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_s[2:0];
      end else begin
        found_s  = found_s;
      end
    end
    if (winner_s == 3'd4) begin
      ptr_next_s = 3'd0;
    end else begin
      ptr_next_s = winner_s + 3'd1;
    end
  end

  // Backpressure: every requester is held off except the winner of an accepting cycle
  always_comb begin
    bus.blocked_in = 5'd0;
    for (int i = 0; i < 5; i++) begin
      bus.blocked_in[i] = bus.req[i] & (stall_s | !(grant_s && (winner_s == 3'(i))));
    end
  end

  // Output-register occupancy transitions
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_s) state_next_s = ST_FULL;
        else         state_next_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (stall_s)      state_next_s = ST_FULL;
        else if (grant_s) state_next_s = ST_FULL;
        else              state_next_s = ST_EMPTY;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_EMPTY;
    else       state_r <= state_next_s;
  end

  // Flit/grant register and per-VC pointers; a stall holds everything
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r      <= 64'd0;
      gnt_r       <= 5'd0;
      rr_ptr_r[0] <= 3'd0;
      rr_ptr_r[1] <= 3'd0;
    end else if (grant_s) begin
      data_r                 <= bus.data_in[{winner_s, 6'd0} +: 64];
      gnt_r                  <= 5'd1 << winner_s;
      rr_ptr_r[bus.polarity] <= ptr_next_s;
    end else if (accept_s) begin
      data_r <= 64'd0;
      gnt_r  <= 5'd0;
    end else begin
      data_r <= data_r;
      gnt_r  <= gnt_r;
    end
  end

`ifdef ROUTER_ARB_PERF_CNT_EN
  logic [15:0] grant_count_r;

  // Saturating count of loaded grants
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_r <= 16'd0;
    end else if (grant_s && (grant_count_r != 16'hFFFF)) begin
      grant_count_r <= grant_count_r + 16'd1;
    end else begin
      grant_count_r <= grant_count_r;
    end
  end

  assign grant_count = grant_count_r;
`endif

  assign bus.send_out = (state_r == ST_FULL);
  assign bus.gnt      = gnt_r;
  assign bus.data_out = data_r;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: directed vector table, hand sequences for stall/reset, and a randomized run against a round-robin reference model.
module tb_router_output_arbiter;

  logic clk;
  logic reset;
  router_output_arbiter_if bus ();
`ifdef ROUTER_ARB_PERF_CNT_EN
  logic [15:0] grant_count;
`endif

  router_output_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave)
`ifdef ROUTER_ARB_PERF_CNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] din [5];

  typedef struct {
    logic       rst;
    logic       pol;
    logic [4:0] req;
    logic       rdy;
    logic [4:0] blk;
    logic       send;
    logic [4:0] gnt;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else             pass_cnt++;
  endtask

  task automatic load_data();
    for (int i = 0; i < 5; i++) bus.data_in[64*i +: 64] = din[i];
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hCAFE_0000_0000_1000 + 64'(i) * 64'h0000_0001_0000_0001;
  endfunction

  function automatic logic [63:0] pat_of_gnt(input logic [4:0] g);
    for (int i = 0; i < 5; i++) if (g == (5'd1 << i)) return pat(i);
    return 64'd0;
  endfunction

  // Drive one cycle's inputs, sample blocked_in before the edge and leave time at edge+1
  task automatic cycle(input logic r, input logic p, input logic [4:0] q, input logic rd,
                       output logic [4:0] blk);
    reset = r; bus.polarity = p; bus.req = q; bus.ready_out = rd;
    #2;
    blk = bus.blocked_in;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] blk;
  int   mptr [2];
  logic msend;
  logic [4:0] mgnt;
  logic [63:0] mdata;

  initial begin
    reset = 1'b1; bus.polarity = 1'b0; bus.req = 5'd0; bus.ready_out = 1'b1; bus.data_in = '0;

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b11110, 1'b1, 5'b00001};
    tbl[2]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b11101, 1'b1, 5'b00010};
    tbl[3]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b11011, 1'b1, 5'b00100};
    tbl[4]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b10111, 1'b1, 5'b01000};
    tbl[5]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b01111, 1'b1, 5'b10000};
    tbl[6]  = '{1'b0, 1'b0, 5'b11111, 1'b1, 5'b11110, 1'b1, 5'b00001};
    tbl[7]  = '{1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 5'b00000};
    tbl[8]  = '{1'b0, 1'b0, 5'b10001, 1'b1, 5'b10000, 1'b1, 5'b00001};
    tbl[9]  = '{1'b0, 1'b1, 5'b10001, 1'b1, 5'b10000, 1'b1, 5'b00001};
    tbl[10] = '{1'b0, 1'b0, 5'b10001, 1'b1, 5'b00001, 1'b1, 5'b10000};
    tbl[11] = '{1'b0, 1'b1, 5'b10001, 1'b1, 5'b00001, 1'b1, 5'b10000};
    tbl[12] = '{1'b0, 1'b0, 5'b10001, 1'b1, 5'b10000, 1'b1, 5'b00001};
    tbl[13] = '{1'b0, 1'b0, 5'b00010, 1'b0, 5'b00010, 1'b1, 5'b00001};
    tbl[14] = '{1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 5'b00000};
    tbl[15] = '{1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 5'b00000};
    for (int i = 0; i < 5; i++) din[i] = pat(i);
    load_data();
    for (int v = 0; v < 16; v++) begin
      cycle(tbl[v].rst, tbl[v].pol, tbl[v].req, tbl[v].rdy, blk);
      chk($sformatf("tbl%0d_blocked", v), 64'(blk), 64'(tbl[v].blk));
      chk($sformatf("tbl%0d_send", v), 64'(bus.send_out), 64'(tbl[v].send));
      chk($sformatf("tbl%0d_gnt", v), 64'(bus.gnt), 64'(tbl[v].gnt));
      chk($sformatf("tbl%0d_data", v), bus.data_out, pat_of_gnt(tbl[v].gnt));
    end

    // ---------------- first grant after reset, pointer moves to 1 ----------------
    din[0] = 64'hA; load_data();
    cycle(1'b1, 1'b0, 5'b00000, 1'b1, blk);
    chk("rst_send", 64'(bus.send_out), 64'd0);
    cycle(1'b0, 1'b0, 5'b00001, 1'b1, blk);
    chk("first_send", 64'(bus.send_out), 64'd1);
    chk("first_data", bus.data_out, 64'hA);
    chk("first_gnt", 64'(bus.gnt), 64'b00001);
    cycle(1'b0, 1'b0, 5'b00011, 1'b1, blk);
    chk("ptr1_gnt", 64'(bus.gnt), 64'b00010);

    // ---------------- stall holds E flit, then W wins ----------------
    din[1] = 64'h55; load_data();
    cycle(1'b1, 1'b0, 5'b00000, 1'b1, blk);
    cycle(1'b0, 1'b0, 5'b00010, 1'b1, blk);
    chk("stall_e_gnt", 64'(bus.gnt), 64'b00010);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 1'b0, 5'b01000, 1'b0, blk);
      chk($sformatf("stall%0d_blocked", s), 64'(blk), 64'b01000);
      chk($sformatf("stall%0d_data", s), bus.data_out, 64'h55);
      chk($sformatf("stall%0d_gnt", s), 64'(bus.gnt), 64'b00010);
      chk($sformatf("stall%0d_send", s), 64'(bus.send_out), 64'd1);
    end
    cycle(1'b0, 1'b0, 5'b01000, 1'b1, blk);
    chk("unstall_blocked", 64'(blk), 64'b00000);
    chk("unstall_gnt", 64'(bus.gnt), 64'b01000);
    chk("unstall_data", bus.data_out, din[3]);

    // ---------------- reset during stall discards flit and pointers ----------------
    cycle(1'b0, 1'b0, 5'b00100, 1'b1, blk);
    cycle(1'b0, 1'b1, 5'b00100, 1'b1, blk);
    cycle(1'b0, 1'b0, 5'b00100, 1'b0, blk);
    chk("pre_rst_send", 64'(bus.send_out), 64'd1);
    cycle(1'b1, 1'b0, 5'b00100, 1'b0, blk);
    chk("rst_stall_send", 64'(bus.send_out), 64'd0);
    chk("rst_stall_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_stall_data", bus.data_out, 64'd0);
    cycle(1'b0, 1'b0, 5'b11111, 1'b1, blk);
    chk("rst_ptr0", 64'(bus.gnt), 64'b00001);
    cycle(1'b0, 1'b1, 5'b11111, 1'b1, blk);
    chk("rst_ptr1", 64'(bus.gnt), 64'b00001);

    // ---------------- randomized run against reference model ----------------
    msend = 1'b0; mgnt = 5'd0; mdata = 64'd0; mptr[0] = 0; mptr[1] = 0;
    for (int c = 0; c < 400; c++) begin
      logic r, p, rd, stall;
      logic [4:0] q, eb;
      int win;
      r  = (c == 0) || ($urandom_range(0, 24) == 0);
      p  = 1'($urandom_range(0, 1));
      q  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) din[i] = ($urandom_range(0, 9) == 0) ? 64'd0 : {$urandom, $urandom};
      load_data();
      stall = msend && !rd;
      win = -1;
      if (!stall && q != 5'd0) begin
        for (int k = 0; k < 5; k++) begin
          int j;
          j = (mptr[p] + k) % 5;
          if (win < 0 && q[j]) win = j;
        end
      end
      for (int i = 0; i < 5; i++) eb[i] = q[i] && (stall || i != win);
      cycle(r, p, q, rd, blk);
      if (!r) chk($sformatf("rnd%0d_blocked", c), 64'(blk), 64'(eb));
      if (r) begin
        msend = 1'b0; mgnt = 5'd0; mdata = 64'd0; mptr[0] = 0; mptr[1] = 0;
      end else if (!stall) begin
        if (win >= 0) begin
          msend = 1'b1; mgnt = 5'd1 << win; mdata = din[win]; mptr[p] = (win + 1) % 5;
        end else begin
          msend = 1'b0; mgnt = 5'd0; mdata = 64'd0;
        end
      end
      chk($sformatf("rnd%0d_send", c), 64'(bus.send_out), 64'(msend));
      chk($sformatf("rnd%0d_gnt", c), 64'(bus.gnt), 64'(mgnt));
      chk($sformatf("rnd%0d_data", c), bus.data_out, mdata);
    end

`ifdef ROUTER_ARB_PERF_CNT_EN
    cycle(1'b1, 1'b0, 5'b00000, 1'b1, blk);
    chk("cnt_reset", 64'(grant_count), 64'd0);
    cycle(1'b0, 1'b0, 5'b00001, 1'b1, blk);
    chk("cnt_one", 64'(grant_count), 64'd1);
    for (int g = 0; g < 70000; g++) begin
      reset = 1'b0; bus.req = 5'b11111; bus.ready_out = 1'b1;
      @(posedge clk);
    end
    #1;
    chk("cnt_sat", 64'(grant_count), 64'hFFFF);
    cycle(1'b0, 1'b0, 5'b11111, 1'b1, blk);
    chk("cnt_hold", 64'(grant_count), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high; clears all state on the clk edge at which it is sampled high.
REQ-003 polarity  input  1  virtual channel in use this cycle: 0 = VC1 (even), 1 = VC2 (odd).
REQ-004 req  input  5  per-input-port request; bit order 0=N, 1=E, 2=S, 3=W, 4=Local.
REQ-005 data_in  input  320  five 64-bit flits; port i occupies bits [64*i+63 : 64*i].
REQ-006 ready_out  input  1  downstream can accept a flit this cycle.
REQ-007 blocked_in  output  5  per-port backpressure to the input channels; combinational.
REQ-008 gnt  output  5  registered one-hot grant; identifies the source of the flit on data_out.
REQ-009 send_out  output  1  registered valid for data_out.
REQ-010 data_out  output  64  registered flit.
REQ-011 grant_count  output  16  saturating count of granted flits; present only when the Configuration macro is defined.

Function
REQ-012 Output register: holds valid/data/gnt. A transfer occurs on any edge where send_out=1 and ready_out=1.
REQ-013 The register can accept a new flit when send_out=0 or ready_out=1.
REQ-014 The block keeps two independent 3-bit round-robin pointers, rr_ptr[0] and rr_ptr[1], one per VC.
  - Legal pointer values: 0..4.
  - The current pointer is rr_ptr[polarity].
REQ-015 Winner selection: when the register can accept and req!=0, the winner is the first set req bit scanning upward from the current pointer, wrapping 4->0. Selection is combinational.
REQ-016 On the accepting edge, the register loads the winner:
  - send_out <= 1
  - data_out <= the winner's data_in slice
  - gnt <= one-hot of the winner
  - rr_ptr[polarity] <= (winner+1) mod 5
REQ-017 Latency: a request accepted in cycle N appears on data_out/send_out in cycle N+1.
REQ-018 When the register can accept and req=0, the register loads send_out<=0, data_out<=0 and gnt<=0. Both pointers are unchanged.
REQ-019 While send_out=1 and ready_out=0 (stall):
  - send_out, data_out and gnt hold their values.
  - No grant is issued.
  - Both pointers are unchanged.
REQ-020 blocked_in[i] = req[i] AND (stall OR i is not the winner). Non-requesting ports see 0.
REQ-021 The pointer of the non-current VC never changes.
REQ-022 Two states are derived from the output register:
  - EMPTY (send_out=0) -> FULL on any grant.
  - FULL -> FULL on transfer with a new grant.
  - FULL -> EMPTY on transfer with req=0.
  - FULL -> FULL (stall) on ready_out=0.
REQ-023 A flit whose value is 0 is forwarded normally when requested; validity comes from req only.
REQ-024 data_in of non-winning ports is ignored.

Reset
REQ-025 On reset: send_out=0, data_out=0, gnt=0, rr_ptr[0]=rr_ptr[1]=0, grant_count=0.
REQ-026 Reset overrides stall and any pending grant. A flit held in the register is discarded.
REQ-027 In the first cycle after reset, an accepting grant follows REQ-015 with pointer 0.

Configuration
REQ-028 Macro ROUTER_ARB_PERF_CNT_EN.
  - Defined: grant_count exists; it increments by 1 on every edge where a grant is loaded and saturates at 16'hFFFF.
  - Undefined: the grant_count port and counter are absent; all other behaviour is identical.

Verification
REQ-029 Reset, then req=5'b00001, polarity=0, ready_out=1, N data=64'hA -> next cycle: send_out=1, data_out=64'hA, gnt=5'b00001; rr_ptr[0]=1.
REQ-030 req=5'b11111 held, polarity=0, ready_out=1 -> gnt sequence 00001, 00010, 00100, 01000, 10000, 00001 (wrap); blocked_in shows 4 ones each cycle.
REQ-031 Alternate polarity 0/1 with req=5'b10001 -> each VC pointer advances independently; VC1 grants N then L, VC2 grants N then L.
REQ-032 Grant E (data 64'h55), then ready_out=0 for 3 cycles with req=5'b01000 -> data_out stays 64'h55; blocked_in=5'b01000; on ready_out=1, W is granted the next cycle.
REQ-033 Assert reset during a stall with send_out=1 -> next cycle: send_out=0, gnt=0, pointers=0.
REQ-034 With ROUTER_ARB_PERF_CNT_EN defined, issue 70000 grants -> grant_count=16'hFFFF and stays there.
